// File: rtl/matrix_scan.sv
// Row-multiplexed 16x16 LED driver: snapshots ball/paddle positions once per frame, shifts each row word out
// column 15 first (two clocks per bit), latches it, then holds the one-hot row select for DWELL cycles.
module matrix_scan #(
    parameter int DWELL      = 16,
    parameter int PADDLE_LEN = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  ball_x,
    input  logic [3:0]  ball_y,
    input  logic [3:0]  lpad,
    input  logic [3:0]  rpad,
    output logic        sdo,
    output logic        sclk,
    output logic        latch,
    output logic [15:0] row,
    output logic        frame_start
);

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam logic [7:0] DWELL_LAST = (DWELL == 0) ? 8'd0 : 8'(DWELL - 1);
    localparam logic [4:0] PAD_EXT    = 5'(PADDLE_LEN - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  rc_q, rc_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  dwell_q, dwell_d;
    logic [15:0] shreg_q, shreg_d;
    logic [15:0] row_nxt_q, row_nxt_d;
    logic [3:0]  snap_bx_q, snap_bx_d;
    logic [3:0]  snap_by_q, snap_by_d;
    logic [3:0]  snap_lp_q, snap_lp_d;
    logic [3:0]  snap_rp_q, snap_rp_d;
    logic        sdo_q, sdo_d;
    logic        sclk_q, sclk_d;
    logic        latch_q, latch_d;
    logic        frame_start_q, frame_start_d;
    logic [15:0] row_q, row_d;

    // Paddle extent is evaluated in 5 bits so a paddle near the bottom clips instead of wrapping.
    function automatic logic [15:0] render(input logic [3:0] bx, input logic [3:0] by,
                                           input logic [3:0] lp, input logic [3:0] rp,
                                           input logic [3:0] r);
        logic [15:0] word;
        word = '0;
        if (by == r)
            word[bx] = 1'b1;
        if ((r >= lp) && ({1'b0, r} <= ({1'b0, lp} + PAD_EXT)))
            word[0] = 1'b1;
        if ((r >= rp) && ({1'b0, r} <= ({1'b0, rp} + PAD_EXT)))
            word[15] = 1'b1;
        return word;
    endfunction

    always_comb begin
        state_d       = state_q;
        rc_d          = rc_q;
        bit_cnt_d     = bit_cnt_q;
        dwell_d       = dwell_q;
        shreg_d       = shreg_q;
        row_nxt_d     = row_nxt_q;
        snap_bx_d     = snap_bx_q;
        snap_by_d     = snap_by_q;
        snap_lp_d     = snap_lp_q;
        snap_rp_d     = snap_rp_q;
        sdo_d         = sdo_q;
        sclk_d        = sclk_q;
        latch_d       = 1'b0;
        frame_start_d = 1'b0;
        // The row select follows the latch strobe by one cycle, so the old row stays lit until then.
        row_d         = latch_q ? row_nxt_q : row_q;

        case (state_q)
            S_LOAD: begin
                if (rc_q == 4'd0) begin
                    snap_bx_d     = ball_x;
                    snap_by_d     = ball_y;
                    snap_lp_d     = lpad;
                    snap_rp_d     = rpad;
                    frame_start_d = 1'b1;
                    shreg_d       = render(ball_x, ball_y, lpad, rpad, rc_q);
                end else begin
                    shreg_d = render(snap_bx_q, snap_by_q, snap_lp_q, snap_rp_q, rc_q);
                end
                bit_cnt_d = '0;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                if (!bit_cnt_q[0]) begin
                    sdo_d  = shreg_q[15];
                    sclk_d = 1'b0;
                end else begin
                    sclk_d  = 1'b1;
                    shreg_d = {shreg_q[14:0], 1'b0};
                end
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd31)
                    state_d = S_LATCH;
            end
            S_LATCH: begin
                sclk_d    = 1'b0;
                latch_d   = 1'b1;
                row_nxt_d = 16'(1) << rc_q;
                dwell_d   = '0;
                if (DWELL == 0) begin
                    rc_d    = rc_q + 4'd1;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (dwell_q == DWELL_LAST) begin
                    rc_d    = rc_q + 4'd1;
                    state_d = S_LOAD;
                end else begin
                    dwell_d = dwell_q + 8'd1;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_LOAD;
            rc_q          <= '0;
            bit_cnt_q     <= '0;
            dwell_q       <= '0;
            shreg_q       <= '0;
            row_nxt_q     <= '0;
            snap_bx_q     <= '0;
            snap_by_q     <= '0;
            snap_lp_q     <= '0;
            snap_rp_q     <= '0;
            sdo_q         <= 1'b0;
            sclk_q        <= 1'b0;
            latch_q       <= 1'b0;
            frame_start_q <= 1'b0;
            row_q         <= '0;
        end else begin
            state_q       <= state_d;
            rc_q          <= rc_d;
            bit_cnt_q     <= bit_cnt_d;
            dwell_q       <= dwell_d;
            shreg_q       <= shreg_d;
            row_nxt_q     <= row_nxt_d;
            snap_bx_q     <= snap_bx_d;
            snap_by_q     <= snap_by_d;
            snap_lp_q     <= snap_lp_d;
            snap_rp_q     <= snap_rp_d;
            sdo_q         <= sdo_d;
            sclk_q        <= sclk_d;
            latch_q       <= latch_d;
            frame_start_q <= frame_start_d;
            row_q         <= row_d;
        end
    end

    assign sdo         = sdo_q;
    assign sclk        = sclk_q;
    assign latch       = latch_q;
    assign row         = row_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_matrix_scan.sv
// Scoreboard bench: a DWELL=2 instance has its serial row words checked against a per-frame model;
// a DWELL=0 instance sharing the same inputs has its latch/frame periods and row stepping checked.
module tb_matrix_scan;

    localparam int PL = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  ball_x = 4'd8, ball_y = 4'd8, lpad = 4'd0, rpad = 4'd0;
    logic        sdo, sclk, latch, frame_start;
    logic [15:0] row;
    logic        sdo_b, sclk_b, latch_b, fs_b;
    logic [15:0] row_b;

    int n_vec = 0;
    int n_bad = 0;
    logic [19:0] sbq[$];

    always #5 clk = ~clk;

    matrix_scan #(.DWELL(2), .PADDLE_LEN(PL)) dut (
        .clk(clk), .reset_n(reset_n), .ball_x(ball_x), .ball_y(ball_y), .lpad(lpad), .rpad(rpad),
        .sdo(sdo), .sclk(sclk), .latch(latch), .row(row), .frame_start(frame_start));

    matrix_scan #(.DWELL(0), .PADDLE_LEN(PL)) dut_b (
        .clk(clk), .reset_n(reset_n), .ball_x(ball_x), .ball_y(ball_y), .lpad(lpad), .rpad(rpad),
        .sdo(sdo_b), .sclk(sclk_b), .latch(latch_b), .row(row_b), .frame_start(fs_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_word(input int bx, input int by, input int lp, input int rp, input int r);
        logic [15:0] w;
        int lbot, rbot;
        w = '0;
        lbot = (lp + PL - 1 > 15) ? 15 : lp + PL - 1;
        rbot = (rp + PL - 1 > 15) ? 15 : rp + PL - 1;
        if (by == r) w[bx] = 1'b1;
        if (r >= lp && r <= lbot) w[0] = 1'b1;
        if (r >= rp && r <= rbot) w[15] = 1'b1;
        return w;
    endfunction

    task automatic push_frame(input int bx, input int by, input int lp, input int rp);
        for (int r = 0; r < 16; r++)
            sbq.push_back({4'(r), model_word(bx, by, lp, rp, r)});
    endtask

    task automatic wait_fs(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frame_start) return;
        end
        chk("fs_timeout", 0, 1);
    endtask

    // Monitor for the DWELL=2 instance: rebuild each word from sclk rising edges.
    logic [15:0] shw = '0;
    int          nbits = 0;
    logic        prev_sclk = 1'b0;
    logic        row_chk = 1'b0;
    logic [3:0]  exp_row = '0;
    logic [19:0] ent;

    always @(negedge clk) begin
        if (!reset_n) begin
            nbits = 0; prev_sclk = 1'b0; row_chk = 1'b0;
        end else begin
            if (sclk && !prev_sclk) begin
                shw = {shw[14:0], sdo};
                nbits++;
            end
            prev_sclk = sclk;
            if (row_chk) begin
                chk("row_sel", row, 16'(1) << exp_row);
                row_chk = 1'b0;
            end
            if (latch) begin
                chk("bits_per_row", nbits, 16);
                chk("latch_fs_overlap", frame_start, 0);
                if (sbq.size() == 0) begin
                    chk("sb_empty", 0, 1);
                end else begin
                    ent = sbq.pop_front();
                    chk($sformatf("word_row%0d", ent[19:16]), shw, ent[15:0]);
                    exp_row = ent[19:16];
                    row_chk = 1'b1;
                end
                nbits = 0;
            end
        end
    end

    // Monitor for the DWELL=0 instance.
    int cyc = 0;
    int last_latch = -1, last_fs = -1, wraps = 0;
    logic [15:0] prev_row_b = '0;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            last_latch = -1; last_fs = -1; prev_row_b = '0;
        end else begin
            if (latch_b) begin
                if (last_latch >= 0) chk("b_latch_period", cyc - last_latch, 34);
                last_latch = cyc;
            end
            if (fs_b) begin
                if (last_fs >= 0) chk("b_frame_period", cyc - last_fs, 544);
                last_fs = cyc;
            end
            if (row_b != prev_row_b) begin
                if (prev_row_b == 16'h0000)
                    chk("b_row_first", row_b, 16'h0001);
                else
                    chk("b_row_step", row_b, {prev_row_b[14:0], prev_row_b[15]});
                if (prev_row_b == 16'h8000) wraps++;
                prev_row_b = row_b;
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_sdo", sdo, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_latch", latch, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_row", row, 16'h0000);

        // Frame 0: ball (8,8), both paddles at the top.
        push_frame(8, 8, 0, 0);
        #2 reset_n = 1'b1;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            chk($sformatf("fs_c%0d", c), frame_start, (c == 0) ? 1 : 0);
            chk($sformatf("latch_c%0d", c), latch, (c == 33) ? 1 : 0);
            chk($sformatf("row_c%0d", c), row, (c >= 34) ? 16'h0001 : 16'h0000);
        end

        // Move the ball during row 5; frame 0 must keep its snapshot.
        repeat (155) @(negedge clk);
        ball_x = 4'd3;
        push_frame(3, 8, 0, 0);
        wait_fs(700);

        rpad = 4'd14; ball_x = 4'd8;
        push_frame(8, 8, 0, 14);
        wait_fs(700);

        ball_x = 4'd0; ball_y = 4'd1; lpad = 4'd0; rpad = 4'd0;
        push_frame(0, 1, 0, 0);
        wait_fs(700);

        ball_x = 4'd5; ball_y = 4'd5; lpad = 4'd2; rpad = 4'd7;
        push_frame(5, 5, 2, 7);
        wait_fs(700);

        // Mid-SHIFT of row 7: reset between clock edges.
        repeat (262) @(negedge clk);
        chk("pre_rst_row", row, 16'h0040);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_sdo", sdo, 0);
        chk("arst_sclk", sclk, 0);
        chk("arst_latch", latch, 0);
        chk("arst_row", row, 16'h0000);
        sbq.delete();
        ball_x = 4'd2; ball_y = 4'd0; lpad = 4'd13; rpad = 4'd1;
        push_frame(2, 0, 13, 1);
        repeat (3) @(negedge clk);
        chk("arst_fs_low", frame_start, 0);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("fs_after_rst", frame_start, 1);
        repeat (80) @(negedge clk);

        chk("b_wrap_seen", (wraps > 0) ? 1 : 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/matrix_scan.md
# matrix_scan

Row-multiplexed display driver for the 16x16 LED playfield: the consumer of the ball's 4-bit `x`/`y` position and of both paddle positions. Each frame it snapshots the object positions once. It then renders one row at a time into a 16-bit column word and shifts that word serially to an external column shift register. It latches the word and drives a one-hot row select, sitting between the game logic and the LED matrix pins.

## Interface
- `DWELL`, 16, hold cycles per row after latch, range 0..255
- `PADDLE_LEN`, 3, paddle height in pixels, range 1..16

- `clk`  in  1  system clock (~1000Hz domain)
- `reset_n`  in  1  asynchronous, active-low reset
- `ball_x`  in  4  ball column (0 = left edge)
- `ball_y`  in  4  ball row (0 = top)
- `lpad`  in  4  top row of left paddle (column 0)
- `rpad`  in  4  top row of right paddle (column 15)
- `sdo`  out  1  serial column data
- `sclk`  out  1  shift clock to column register; data sampled on its rising edge
- `latch`  out  1  one-cycle column-register latch strobe
- `row`  out  16  one-hot active-high row select; `row[r]` drives row r
- `frame_start`  out  1  one-cycle pulse at the start of every frame

## Operation
- One clock. Reset is asynchronous and active-low.
- FSM states: LOAD, SHIFT, LATCH, HOLD. Row counter `rc` runs 0..15.
- LOAD (1 cycle):
  - If `rc==0`: capture `ball_x`, `ball_y`, `lpad`, `rpad` into snapshot registers and assert `frame_start`.
  - Load the 16-bit shift register with the row-`rc` word.
  - For `rc==0`, compute the word from the live inputs being captured. Otherwise compute it from the snapshot.
- Word bit c is 1 when any of the following holds (OR):
  - `ball_y==rc` and `ball_x==c`;
  - c==0 and `lpad <= rc <= min(lpad+PADDLE_LEN-1,15)`;
  - c==15 and the same test holds with `rpad`.
- Paddles clip at row 15 and never wrap to row 0. Overlap of ball and paddle yields a single set bit.
- SHIFT (32 cycles): bits are sent column 15 first, down to column 0, two cycles per bit.
  - Phase 0: `sdo` = bit, `sclk`=0.
  - Phase 1: `sdo` held, `sclk`=1.
- LATCH (1 cycle): `latch`=1. The registered `row` is updated to onehot(`rc`), visible from the next cycle.
- HOLD: `DWELL` cycles, outputs static. Then `rc` increments (15 wraps to 0) and the FSM returns to LOAD. With `DWELL=0`, LATCH goes straight to LOAD.
- `row` keeps showing the previously latched row during LOAD/SHIFT of the next row, so the display is never blanked.
- Inputs are sampled only in the `rc==0` LOAD. Changes mid-frame take effect at the next frame.

## Timing
- Reset values:
  - `sdo`=0, `sclk`=0, `latch`=0, `frame_start`=0, `row`=16'h0000.
  - FSM = LOAD, `rc`=0, snapshot = 0.
- Reset assertion clears all outputs immediately, independent of `clk`.
- First edge after reset release is cycle 0:
  - Cycle 0: LOAD, `frame_start`=1.
  - Cycles 1..32: SHIFT.
  - Cycle 33: LATCH.
  - Cycles 34..33+DWELL: HOLD.
- Row period = 34+`DWELL` cycles. Frame period = 16*(34+`DWELL`).
- `frame_start` and `latch` are exactly one cycle wide. They never coincide.
- Reset mid-operation abandons the current row. After release, the block restarts at row 0 with a fresh snapshot.
- All outputs are registered; no combinational path runs from inputs to outputs.

## Test plan
- **Frame 0 content.** `DWELL=2`; release reset with ball (8,8), `lpad`=0, `rpad`=0.
  - `frame_start` high at cycle 0 only.
  - Row 0 bit stream on `sclk` rising edges is 1,0×14,1 (word 0x8001).
  - `latch` at cycle 33; `row`=0x0001 from cycle 34.
  - Row 8 word = 0x0100; row 3 word = 0x0000.
- **Paddle clipping.** `rpad`=14, `PADDLE_LEN`=3.
  - Rows 14 and 15 have bit 15 set.
  - Row 0 bit 15 is clear (no wrap).
- **Overlap.** Ball (0,1), `lpad`=0.
  - Row 1 word = 0x8001 (left paddle and ball share bit 0; right paddle sets bit 15).
  - No extra bits set.
- **Snapshot stability.** Move `ball_x` from 8 to 3 during row 5 of a frame.
  - Row 8 of that frame still shows 0x0100.
  - The next frame's row 8 shows 0x0008.
- **Async reset mid-frame.** Drop `reset_n` mid-SHIFT of row 7, between clock edges.
  - `sdo`/`sclk`/`latch`/`row` go to 0 before the next edge.
  - After release, `frame_start` fires at cycle 0 and row 0 is rendered.
- **Zero dwell and wrap.** `DWELL=0`.
  - `latch` pulses every 34 cycles.
  - `row` steps 0x0001 → … → 0x8000 → 0x0001.
  - `frame_start` recurs every 544 cycles.
